// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: the fetch stage's two buses.
//   Memory side:  imem_req/imem_addr out, imem_ready/imem_rdata in.
//   Execute side: instr_valid plus the instruction and decoded fields out;
//                 instr_ack/branch/zero/jump in.
// modport master belongs to the fetch stage. modport slave belongs to
// the memory/execute side.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_ack;
  logic        branch;
  logic        zero;
  logic        jump;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, rs, rt, rd,
           shamt, funct, imm16, pc, pc_plus4,
    input  imem_ready, imem_rdata, instr_ack, branch, zero, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, rs, rt, rd,
           shamt, funct, imm16, pc, pc_plus4,
    output imem_ready, imem_rdata, instr_ack, branch, zero, jump
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: MIPS fetch stage. It owns the PC, fetches words over a
// request/ready handshake and holds them in the instruction register until
// execute acknowledges them.
// Optional feature: define IF_PERF_CNT_EN to add the instr_count
// retired-instruction counter port.
//
// Handshake semantics:
//   Memory side:  imem_req stays high for the whole of FETCH, and imem_addr
//                 stays stable while it is high. The word is taken on the
//                 first rising edge that sees imem_ready=1. imem_ready is
//                 ignored outside FETCH.
//   Execute side: instr_valid stays high for the whole of EXEC. The held
//                 instruction retires on the first rising edge that sees
//                 instr_ack=1. branch/zero/jump are sampled on that edge.
//                 All four inputs are ignored outside EXEC.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_if.master        bus,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]                instr_count,
`endif
  output logic [1:0]                 state_dbg
);

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] FETCH = 2'b01;
  localparam logic [1:0] EXEC  = 2'b10;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // The next PC is used only on the acknowledge edge. Jump takes priority over branch.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jump) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (bus.branch && bus.zero) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // Sequencer: IDLE -> FETCH (wait for ready) -> EXEC (wait for ack) -> FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      instr <= 32'h0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.imem_ready) begin
            instr <= bus.imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (bus.instr_ack) begin
            pc    <= next_pc;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  // Counts retired instructions. The counter wraps naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_count <= 32'h0;
    end else if (state == EXEC && bus.instr_ack) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

  assign bus.imem_req    = (state == FETCH);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = (state == EXEC);
  assign bus.instr       = instr;
  assign bus.opcode      = instr[31:26];
  assign bus.rs          = instr[25:21];
  assign bus.rt          = instr[20:16];
  assign bus.rd          = instr[15:11];
  assign bus.shamt       = instr[10:6];
  assign bus.funct       = instr[5:0];
  assign bus.imm16       = instr[15:0];
  assign bus.pc          = pc;
  assign bus.pc_plus4    = pc_plus4;
  assign state_dbg       = state;

endmodule
